imem_fetch_unit: RTL and testbench

Parametrised instruction memory for the pipelined CPU. It replaces the fixed 128×32 tri-state SRAM with separate program-load and fetch ports and a registered, handshaked fetch path. After reset, a clear engine writes a NOP word into every entry. An optional parity check flags corrupted words on fetch. It sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_sram_array.sv | 31 +++
 rtl/imem_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_imem_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types, default parameters and parity helper for the instruction memory.
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_ADX_WIDTH  = 7;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_NOP_WORD = '0;

  // Callers zero-extend into this width; zero padding leaves parity unchanged.
  localparam int PARITY_MAX_W = 256;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_sram_array.sv
// DEPTH x WIDTH storage array, one synchronous write port and one registered read port.
// A same-address read and write in one cycle returns the old contents.
module imem_sram_array #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int ADX_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADX_WIDTH-1:0] wr_adx,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADX_WIDTH-1:0] rd_adx,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_adx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_adx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with clear-on-reset engine, program-load port and a pipelined fetch port.
// Optional stored parity is enabled by defining IMEM_PARITY_EN.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADX_WIDTH  = DEF_ADX_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(DEF_NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADX_WIDTH-1:0]  fetch_adx,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  addr_err,
  input  logic                  load_en,
  input  logic [ADX_WIDTH-1:0]  load_adx,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy
`ifdef IMEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  // One extra counter bit lets DEPTH = 2^ADX_WIDTH be reached without wrapping.
  localparam logic [ADX_WIDTH:0] LAST_ADX  = (ADX_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADX_WIDTH:0] DEPTH_EXT = (ADX_WIDTH+1)'(DEPTH);
  localparam logic [ADX_WIDTH:0] CNT_ONE   = (ADX_WIDTH+1)'(1);

  state_t                 state_reg, state_next;
  logic [ADX_WIDTH:0]     clr_cnt_reg, clr_cnt_next;

  logic                   wr_en;
  logic [ADX_WIDTH-1:0]   wr_adx;
  logic [DATA_WIDTH-1:0]  wr_word;
  logic [WORD_W-1:0]      wr_data;
  logic [WORD_W-1:0]      rd_data;

  logic                   fetch_accept;
  logic                   fetch_in_range;
  logic                   load_in_range;

  logic                   s1_valid_reg;
  logic                   s1_oor_reg;
  logic                   fetch_valid_reg;
  logic [DATA_WIDTH-1:0]  fetch_data_reg;
  logic                   addr_err_reg;

  assign fetch_in_range = {1'b0, fetch_adx} < DEPTH_EXT;
  assign load_in_range  = {1'b0, load_adx} < DEPTH_EXT;
  assign fetch_ready    = (state_reg == RUN);
  assign busy           = (state_reg == CLEAR);
  assign fetch_accept   = fetch_req && fetch_ready;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    wr_en        = 1'b0;
    wr_adx       = load_adx;
    wr_word      = load_data;
    case (state_reg)
      CLEAR: begin
        wr_en        = 1'b1;
        wr_adx       = clr_cnt_reg[ADX_WIDTH-1:0];
        wr_word      = NOP_WORD;
        clr_cnt_next = clr_cnt_reg + CNT_ONE;
        if (clr_cnt_reg == LAST_ADX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        wr_en = load_en && load_in_range;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign wr_data = {even_parity(PARITY_MAX_W'(wr_word)), wr_word};
`else
  assign wr_data = wr_word;
`endif

  imem_sram_array #(
    .WIDTH     (WORD_W),
    .DEPTH     (DEPTH),
    .ADX_WIDTH (ADX_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_adx  (wr_adx),
    .wr_data (wr_data),
    .rd_en   (fetch_accept && fetch_in_range),
    .rd_adx  (fetch_adx),
    .rd_data (rd_data)
  );

  // Stage 1 tracks the RAM read; stage 2 forms the held output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= CLEAR;
      clr_cnt_reg     <= '0;
      s1_valid_reg    <= 1'b0;
      s1_oor_reg      <= 1'b0;
      fetch_valid_reg <= 1'b0;
      fetch_data_reg  <= NOP_WORD;
      addr_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_cnt_reg     <= clr_cnt_next;
      s1_valid_reg    <= fetch_accept;
      if (fetch_accept) begin
        s1_oor_reg <= !fetch_in_range;
      end
      fetch_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        addr_err_reg   <= s1_oor_reg;
        fetch_data_reg <= s1_oor_reg ? NOP_WORD : rd_data[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (s1_valid_reg) begin
      parity_err_reg <= !s1_oor_reg &&
        (even_parity(PARITY_MAX_W'(rd_data[DATA_WIDTH-1:0])) != rd_data[DATA_WIDTH]);
    end
  end

  assign parity_err = parity_err_reg;
`endif

  assign fetch_valid = fetch_valid_reg;
  assign fetch_data  = fetch_data_reg;
  assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit (default 128-deep and a 100-deep instance).
// Parity scenarios compile in when IMEM_PARITY_EN is defined.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        fetch_req, load_en;
  logic [6:0]  fetch_adx, load_adx;
  logic [31:0] load_data;
  logic        fetch_ready, fetch_valid, addr_err, busy;
  logic [31:0] fetch_data;

  logic        d_fetch_req, d_load_en;
  logic [6:0]  d_fetch_adx, d_load_adx;
  logic [31:0] d_load_data;
  logic        d_fetch_ready, d_fetch_valid, d_addr_err, d_busy;
  logic [31:0] d_fetch_data;

`ifdef IMEM_PARITY_EN
  logic        parity_err, d_parity_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  imem_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_adx   (fetch_adx),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .addr_err    (addr_err),
    .load_en     (load_en),
    .load_adx    (load_adx),
    .load_data   (load_data),
    .busy        (busy)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  imem_fetch_unit #(.DEPTH(100)) dut100 (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (d_fetch_req),
    .fetch_adx   (d_fetch_adx),
    .fetch_ready (d_fetch_ready),
    .fetch_valid (d_fetch_valid),
    .fetch_data  (d_fetch_data),
    .addr_err    (d_addr_err),
    .load_en     (d_load_en),
    .load_adx    (d_load_adx),
    .load_data   (d_load_data),
    .busy        (d_busy)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (d_parity_err)
`endif
  );

  // One active edge, then settle on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [6:0] adx);
    fetch_req = 1'b1;
    fetch_adx = adx;
    tick();
    fetch_req = 1'b0;
    tick();
    $display("fetch adx=%0d valid=%b data=%h err=%b", adx, fetch_valid, fetch_data, addr_err);
  endtask

  task automatic d_fetch(input logic [6:0] adx);
    d_fetch_req = 1'b1;
    d_fetch_adx = adx;
    tick();
    d_fetch_req = 1'b0;
    tick();
    $display("fetch100 adx=%0d valid=%b data=%h err=%b", adx, d_fetch_valid, d_fetch_data, d_addr_err);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_req = 1'b0; fetch_adx = '0; load_en = 1'b0; load_adx = '0; load_data = '0;
    d_fetch_req = 1'b0; d_fetch_adx = '0; d_load_en = 1'b0; d_load_adx = '0; d_load_data = '0;
    tick();
    tick();
    $display("reset applied");
    total++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", fetch_valid); else passed++;
    total++; if (fetch_data !== 32'h0) $display("FAIL reset_data got %h want 00000000", fetch_data); else passed++;
    total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", addr_err); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else passed++;
    total++; if (fetch_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", fetch_ready); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int cnt, cnt100;
    bit saw_valid;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    total++; if (busy !== 1'b1) $display("FAIL midclear_busy got %b want 1", busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset at clear cycle 50");
    cnt = 0; cnt100 = 0; saw_valid = 1'b0;
    fetch_req = 1'b1; fetch_adx = 7'd0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b1) cnt++;
      if (d_busy === 1'b1) cnt100++;
      if (fetch_valid !== 1'b0) saw_valid = 1'b1;
      if (busy !== 1'b1 && d_busy !== 1'b1) break;
      load_en = (i == 10); load_adx = 7'd0; load_data = 32'hAAAA5555;
      tick();
    end
    fetch_req = 1'b0; load_en = 1'b0;
    $display("clear done busy_cycles=%0d busy100_cycles=%0d", cnt, cnt100);
    total++; if (cnt !== 128) $display("FAIL clear_cycles got %0d want 128", cnt); else passed++;
    total++; if (cnt100 !== 100) $display("FAIL clear_cycles100 got %0d want 100", cnt100); else passed++;
    total++; if (saw_valid !== 1'b0) $display("FAIL busy_fetch_ignored got valid=1 want 0"); else passed++;
    total++; if (fetch_ready !== 1'b1) $display("FAIL ready_after_clear got %b want 1", fetch_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL busy_after_clear got %b want 0", busy); else passed++;
  endtask

  task automatic test_idle_fetch();
    logic [6:0] adxs [3];
    adxs = '{7'd0, 7'd64, 7'd127};
    for (int i = 0; i < 3; i++) begin
      do_fetch(adxs[i]);
      total++; if (fetch_valid !== 1'b1) $display("FAIL idle_valid adx=%0d got %b want 1", adxs[i], fetch_valid); else passed++;
      total++; if (fetch_data !== 32'h0) $display("FAIL idle_data adx=%0d got %h want 00000000", adxs[i], fetch_data); else passed++;
      total++; if (addr_err !== 1'b0) $display("FAIL idle_addr_err adx=%0d got %b want 0", adxs[i], addr_err); else passed++;
    end
  endtask

  task automatic test_load_fetch();
    load_en = 1'b1; load_adx = 7'd5; load_data = 32'hDEADBEEF;
    tick();
    $display("load adx=5 data=deadbeef");
    load_en = 1'b0;
    fetch_req = 1'b1; fetch_adx = 7'd5;
    tick();
    fetch_req = 1'b0;
    total++; if (fetch_valid !== 1'b0) $display("FAIL latency_early_valid got %b want 0", fetch_valid); else passed++;
    tick();
    $display("fetch adx=5 valid=%b data=%h err=%b", fetch_valid, fetch_data, addr_err);
    total++; if (fetch_valid !== 1'b1) $display("FAIL load_fetch_valid got %b want 1", fetch_valid); else passed++;
    total++; if (fetch_data !== 32'hDEADBEEF) $display("FAIL load_fetch_data got %h want deadbeef", fetch_data); else passed++;
    tick();
    total++; if (fetch_valid !== 1'b0) $display("FAIL hold_valid got %b want 0", fetch_valid); else passed++;
    total++; if (fetch_data !== 32'hDEADBEEF) $display("FAIL hold_data got %h want deadbeef", fetch_data); else passed++;
  endtask

  task automatic test_same_cycle();
    load_en = 1'b1; load_adx = 7'd9; load_data = 32'h12345678;
    fetch_req = 1'b1; fetch_adx = 7'd9;
    tick();
    load_en = 1'b0; fetch_req = 1'b0;
    tick();
    $display("load+fetch adx=9 valid=%b data=%h", fetch_valid, fetch_data);
    total++; if (fetch_valid !== 1'b1) $display("FAIL rbw_valid got %b want 1", fetch_valid); else passed++;
    total++; if (fetch_data !== 32'h0) $display("FAIL rbw_old_data got %h want 00000000", fetch_data); else passed++;
    do_fetch(7'd9);
    total++; if (fetch_data !== 32'h12345678) $display("FAIL rbw_new_data got %h want 12345678", fetch_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  adxs [4];
    logic [31:0] vals [4];
    adxs = '{7'd20, 7'd21, 7'd22, 7'd127};
    vals = '{32'h01020304, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFEEDFACE};
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_adx = adxs[i]; load_data = vals[i];
      tick();
      $display("load adx=%0d data=%h", adxs[i], vals[i]);
    end
    load_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_req = (i < 4);
      fetch_adx = (i < 4) ? adxs[i] : 7'd0;
      tick();
      if (i >= 1) begin
        $display("b2b fetch adx=%0d valid=%b data=%h", adxs[i-1], fetch_valid, fetch_data);
        total++; if (fetch_valid !== 1'b1) $display("FAIL b2b_valid adx=%0d got %b want 1", adxs[i-1], fetch_valid); else passed++;
        total++; if (fetch_data !== vals[i-1]) $display("FAIL b2b_data adx=%0d got %h want %h", adxs[i-1], fetch_data, vals[i-1]); else passed++;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_out_of_range();
    d_fetch(7'd120);
    total++; if (d_fetch_valid !== 1'b1) $display("FAIL oor_valid got %b want 1", d_fetch_valid); else passed++;
    total++; if (d_fetch_data !== 32'h0) $display("FAIL oor_data got %h want 00000000", d_fetch_data); else passed++;
    total++; if (d_addr_err !== 1'b1) $display("FAIL oor_addr_err got %b want 1", d_addr_err); else passed++;
    tick();
    total++; if (d_addr_err !== 1'b1) $display("FAIL oor_err_hold got %b want 1", d_addr_err); else passed++;
    d_fetch(7'd99);
    total++; if (d_addr_err !== 1'b0) $display("FAIL last_in_range_err got %b want 0", d_addr_err); else passed++;
    d_fetch(7'd100);
    total++; if (d_addr_err !== 1'b1) $display("FAIL first_oor_err got %b want 1", d_addr_err); else passed++;
    d_load_en = 1'b1; d_load_adx = 7'd0; d_load_data = 32'h0BADF00D;
    tick();
    d_load_adx = 7'd120; d_load_data = 32'hCAFEF00D;
    tick();
    d_load_en = 1'b0;
    $display("load100 adx=0 data=0badf00d, adx=120 data=cafef00d");
    d_fetch(7'd0);
    total++; if (d_fetch_data !== 32'h0BADF00D) $display("FAIL dropped_load_data got %h want 0badf00d", d_fetch_data); else passed++;
    total++; if (d_addr_err !== 1'b0) $display("FAIL dropped_load_err got %b want 0", d_addr_err); else passed++;
    d_fetch(7'd120);
    total++; if (d_fetch_data !== 32'h0) $display("FAIL oor_after_load_data got %h want 00000000", d_fetch_data); else passed++;
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    load_en = 1'b1; load_adx = 7'd3; load_data = 32'hFFFF0000;
    tick();
    load_en = 1'b0;
    dut.u_ram.mem[3][0] = ~dut.u_ram.mem[3][0];
    do_fetch(7'd3);
    $display("parity fetch adx=3 parity_err=%b", parity_err);
    total++; if (fetch_data !== 32'hFFFF0001) $display("FAIL parity_corrupt_data got %h want ffff0001", fetch_data); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL parity_corrupt got %b want 1", parity_err); else passed++;
    do_fetch(7'd5);
    $display("parity fetch adx=5 parity_err=%b", parity_err);
    total++; if (parity_err !== 1'b0) $display("FAIL parity_clean got %b want 0", parity_err); else passed++;
    d_fetch(7'd120);
    total++; if (d_parity_err !== 1'b0) $display("FAIL parity_oor got %b want 0", d_parity_err); else passed++;
  endtask
`endif

  task automatic test_reset_mid_fetch();
    fetch_req = 1'b1; fetch_adx = 7'd5;
    tick();
    fetch_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset during fetch of adx=5");
    total++; if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); else passed++;
    total++; if (fetch_data !== 32'h0) $display("FAIL rst_fetch_data got %h want 00000000", fetch_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rst_fetch_busy got %b want 1", busy); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_clear();
    test_idle_fetch();
    test_load_fetch();
    test_same_cycle();
    test_back_to_back();
    test_out_of_range();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
